// File: rtl/sdspi_req_arbiter.sv
// Round-robin arbiter sharing one sdspihost command port between N_REQ requesters.
// Optional busy watchdog enabled by defining SDSPI_ARB_TIMEOUT_EN.
module sdspi_req_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  output logic [N_REQ-1:0]        gnt,
  input  logic [5*N_REQ-1:0]      req_cmd,
  input  logic [ADDR_W*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0]      req_data_in,
  output logic [N_REQ-1:0]        req_busy,
  output logic [2:0]              owner,
  input  logic                    spi_busy,
  output logic                    spi_r_block,
  output logic                    spi_r_multi_block,
  output logic                    spi_r_byte,
  output logic                    spi_w_block,
  output logic                    spi_w_byte,
  output logic [ADDR_W-1:0]       spi_block_addr,
  output logic [7:0]              spi_data_in,
  output logic                    spi_rst,
  output logic                    timeout
);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_DRAIN} state_t;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("sdspi_req_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [2:0]        owner_q, owner_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [4:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              rst_dly_q;
  logic              to_fire;

  logic [7:0]        req_ext;
  logic [2:0]        pick;
  logic              pick_vld;
  logic [4:0]        sel_cmd;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_din;

  // Widen req to 8 bits so it can be indexed by the 3-bit owner/pick values.
  always_comb begin
    req_ext = '0;
    req_ext[N_REQ-1:0] = req;
  end

  // First requester after the pointer, with wrap-around.
  always_comb begin
    logic [3:0] idx;
    idx      = '0;
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      if (!pick_vld && req_ext[idx[2:0]]) begin
        pick     = idx[2:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_cmd  = '0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        sel_cmd  = req_cmd[5*i +: 5];
        sel_addr = req_addr[ADDR_W*i +: ADDR_W];
        sel_din  = req_data_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cmd_d   = '0;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = N_REQ'(8'b1 << pick);
          owner_d = pick;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (!req_ext[owner_q]) begin
          gnt_d   = '0;
          ptr_d   = owner_q;
          state_d = spi_busy ? S_DRAIN : S_IDLE;
        end else begin
          cmd_d  = sel_cmd;
          addr_d = sel_addr;
          din_d  = sel_din;
        end
      end
      S_DRAIN: begin
        if (!spi_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Watchdog abort: host gets reset, ownership is revoked and rotation moves on.
    if (to_fire) begin
      state_d = S_IDLE;
      gnt_d   = '0;
      cmd_d   = '0;
      ptr_d   = owner_q;
    end
  end

  always_ff @(posedge clk) begin
    rst_dly_q <= rst;
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= 3'(N_REQ - 1);
      cmd_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

`ifdef SDSPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]       to_pulse_q, to_pulse_d;
  logic             timeout_q, timeout_d;

  // Counts consecutive busy cycles while someone holds or drains the host.
  always_comb begin
    to_cnt_d   = '0;
    to_fire    = 1'b0;
    to_pulse_d = (to_pulse_q != 2'd0) ? to_pulse_q - 2'd1 : 2'd0;
    timeout_d  = timeout_q;
    if ((state_q != S_IDLE) && spi_busy) begin
      if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        to_fire    = 1'b1;
        to_pulse_d = 2'd2;
        timeout_d  = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q   <= '0;
      to_pulse_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      to_cnt_q   <= to_cnt_d;
      to_pulse_q <= to_pulse_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
  assign spi_rst = rst | rst_dly_q | (to_pulse_q != 2'd0);
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
  assign spi_rst = rst | rst_dly_q;
`endif

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign req_busy = ~gnt_q | {N_REQ{spi_busy}};
  assign {spi_w_byte, spi_w_block, spi_r_byte, spi_r_multi_block, spi_r_block} = cmd_q;
  assign spi_block_addr = addr_q;
  assign spi_data_in    = din_q;

endmodule

// File: tb/tb_sdspi_req_arbiter.sv
// Bench for sdspi_req_arbiter with four requesters; grant order tracked by a scoreboard queue.
module tb_sdspi_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [5*N-1:0]  req_cmd;
  logic [AW*N-1:0] req_addr;
  logic [8*N-1:0]  req_data_in;
  logic [N-1:0]    req_busy;
  logic [2:0]      owner;
  logic            spi_busy;
  logic            spi_r_block, spi_r_multi_block, spi_r_byte, spi_w_block, spi_w_byte;
  logic [AW-1:0]   spi_block_addr;
  logic [7:0]      spi_data_in;
  logic            spi_rst;
  logic            timeout;

  int checks = 0;
  int errors = 0;
  int exp_owner_q[$];
  logic [N-1:0] prev_gnt = '0;
  logic [AW-1:0] addr_tbl [N] = '{32'h0000_0010, 32'h0000_0099, 32'h0000_1002, 32'h0000_1003};
  logic [7:0]    din_tbl  [N] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

  sdspi_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_data_in(req_data_in), .req_busy(req_busy), .owner(owner), .spi_busy(spi_busy),
    .spi_r_block(spi_r_block), .spi_r_multi_block(spi_r_multi_block), .spi_r_byte(spi_r_byte),
    .spi_w_block(spi_w_block), .spi_w_byte(spi_w_byte), .spi_block_addr(spi_block_addr),
    .spi_data_in(spi_data_in), .spi_rst(spi_rst), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every new grant is matched against the next expected owner.
  always @(negedge clk) begin
    if (gnt !== prev_gnt) begin
      if ((|gnt) === 1'b1) begin
        if (exp_owner_q.size() == 0) begin
          chk("gnt_unexpected", 64'(owner), 64'hFF);
        end else begin
          int e;
          e = exp_owner_q.pop_front();
          chk("gnt_order", 64'(owner), 64'(e));
          chk("gnt_onehot", 64'(gnt), 64'(4'b1 << e));
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    rst = 1'b1; req = '0; req_cmd = '0; spi_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[AW*i +: AW]  = addr_tbl[i];
      req_data_in[8*i +: 8] = din_tbl[i];
    end
    tick();
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_owner", 64'(owner), 0);
    chk("rst_strobes", 64'({spi_w_byte, spi_w_block, spi_r_byte, spi_r_multi_block, spi_r_block}), 0);
    chk("rst_addr", 64'(spi_block_addr), 0);
    chk("rst_din", 64'(spi_data_in), 0);
    chk("rst_timeout", 64'(timeout), 0);
    chk("rst_spi_rst", 64'(spi_rst), 1);
    chk("rst_req_busy", 64'(req_busy), 64'hF);
    tick(); tick();

    // Release reset with two requesters; requester 0 must win first.
    rst = 1'b0; req = 4'b0011;
    exp_owner_q.push_back(0);
    #1 chk("post_rst_pulse", 64'(spi_rst), 1);
    tick();
    chk("first_gnt", 64'(gnt), 64'b0001);
    chk("first_owner", 64'(owner), 0);
    chk("first_req_busy", 64'(req_busy), 64'b1110);
    chk("spi_rst_low", 64'(spi_rst), 0);

    // Owner strobes r_block, non-owner strobes w_byte.
    req_cmd[0] = 1'b1; req_cmd[9] = 1'b1;
    tick();
    chk("own_r_block", 64'(spi_r_block), 1);
    chk("own_w_byte_masked", 64'(spi_w_byte), 0);
    chk("own_addr", 64'(spi_block_addr), 64'h10);
    chk("own_din", 64'(spi_data_in), 64'hA5);

    // Owner drops req while busy: drain for 20 busy cycles.
    req_cmd = '0; spi_busy = 1'b1; req[0] = 1'b0;
    tick();
    chk("drain_gnt", 64'(gnt), 0);
    chk("drain_req_busy", 64'(req_busy), 64'hF);
    req_cmd[9] = 1'b1;
    tick();
    chk("drain_w_byte_masked", 64'(spi_w_byte), 0);
    chk("drain_addr_hold", 64'(spi_block_addr), 64'h10);
    for (int c = 0; c < 18; c++) tick();
    req_cmd = '0; spi_busy = 1'b0;
    exp_owner_q.push_back(1);
    tick();
    chk("drain_exit_gnt", 64'(gnt), 0);
    tick();
    chk("drain_next_gnt", 64'(gnt), 64'b0010);

    // Reset mid-transfer while owner 1 is strobing.
    req_cmd[9] = 1'b1;
    tick();
    chk("w_byte_pass", 64'(spi_w_byte), 1);
    chk("w_byte_din", 64'(spi_data_in), 64'h3C);
    spi_busy = 1'b1; rst = 1'b1;
    #1 chk("rst_mid_spi_rst", 64'(spi_rst), 1);
    tick();
    chk("rst_mid_gnt", 64'(gnt), 0);
    chk("rst_mid_strobe", 64'(spi_w_byte), 0);
    tick();
    rst = 1'b0; req_cmd = '0; spi_busy = 1'b0; req = 4'b1111;
    foreach (addr_tbl[i]) exp_owner_q.push_back(i);
    exp_owner_q.push_back(0);
    #1 chk("rst_mid_tail", 64'(spi_rst), 1);
    tick();
    chk("rst_mid_regrant", 64'(gnt), 64'b0001);
    chk("rst_mid_tail_end", 64'(spi_rst), 0);

    // Fairness: each owner does one transaction and releases.
    for (int t = 0; t < N; t++) begin
      int o;
      for (int w = 0; w < 10 && gnt == '0; w++) tick();
      chk("fair_gnt_wait", 64'(|gnt), 1);
      o = int'(owner);
      req_cmd = 20'(1) << (5*o + 2);
      tick();
      chk("fair_r_byte", 64'(spi_r_byte), 1);
      chk("fair_addr", 64'(spi_block_addr), 64'(addr_tbl[o]));
      req_cmd = '0; spi_busy = 1'b1;
      tick();
      chk("fair_req_busy", 64'(req_busy), 64'hF);
      tick();
      spi_busy = 1'b0; req[o] = 1'b0;
      tick();
      chk("fair_release", 64'(gnt), 0);
      req[o] = 1'b1;
      tick();
    end
    chk("fair_wrap", 64'(gnt), 64'b0001);

`ifdef SDSPI_ARB_TIMEOUT_EN
    // Busy stuck high: watchdog fires on the 64th busy cycle.
    req = 4'b0001; spi_busy = 1'b1;
    for (int c = 0; c < 63; c++) tick();
    chk("to_not_yet", 64'(timeout), 0);
    chk("to_gnt_held", 64'(gnt), 64'b0001);
    tick();
    chk("to_fire_gnt", 64'(gnt), 0);
    chk("to_fire_flag", 64'(timeout), 1);
    chk("to_fire_rst0", 64'(spi_rst), 1);
    req = '0; spi_busy = 1'b0;
    tick();
    chk("to_fire_rst1", 64'(spi_rst), 1);
    tick();
    chk("to_fire_rst2", 64'(spi_rst), 0);
    chk("to_sticky", 64'(timeout), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("to_cleared", 64'(timeout), 0);
`endif

    req = '0;
    for (int c = 0; c < 4; c++) tick();
    chk("sb_empty", 64'(exp_owner_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdspi_req_arbiter.md
Name: sdspi_req_arbiter

Overview:
Shares one sdspihost command interface between N_REQ requesters, such as the autotest FSM and the UUT-side loader.
- Round-robin grant; each grant is held for a whole transaction.
- Non-owner command strobes are masked.
- The grant never changes hands while the host is busy.
- Sits between the requesters and the sdspihost instance; drives the host's command, address, data_in and reset inputs.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 32, block address width
TIMEOUT_CYCLES, 1048576, busy watchdog limit (used only with SDSPI_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  N_REQ  request per requester; level, held for the whole ownership
gnt  out  N_REQ  one-hot grant (all-zero when no owner)
req_cmd  in  5*N_REQ  per requester {w_byte,w_block,r_byte,r_multi_block,r_block}; slice i = bits [5i+4:5i]
req_addr  in  ADDR_W*N_REQ  per-requester block address
req_data_in  in  8*N_REQ  per-requester write byte
req_busy  out  N_REQ  spi_busy for the owner; 1 for every non-owner
owner  out  3  index of the current owner; valid only when |gnt
spi_busy  in  1  host busy
spi_r_block, spi_r_multi_block, spi_r_byte, spi_w_block, spi_w_byte  out  1 each  host command strobes
spi_block_addr  out  ADDR_W  host block address
spi_data_in  out  8  host write byte
spi_rst  out  1  host reset
timeout  out  1  sticky watchdog flag (tied 0 without the macro)

Behaviour:
- Reset values:
  - gnt=0, owner=0, all spi strobes=0, spi_block_addr=0, spi_data_in=0, timeout=0.
  - spi_rst=1 during rst, and for 1 cycle after rst falls.
  - RR pointer = N_REQ-1, so requester 0 wins first.
- States: IDLE, OWN, DRAIN.
- IDLE:
  - If any req, pick the first requester with req=1 searching from pointer+1 with wrap-around.
  - Next cycle: gnt[i]=1, owner=i, state OWN.
  - Only one arbitration per cycle. Latency req→gnt is 1 cycle.
- OWN:
  - Command strobes, address and data_in are registered from the owner's slice. Latency owner input → spi_* is 1 cycle.
  - All other slices are ignored.
  - If req[owner]=0 and spi_busy=0: gnt→0, pointer=owner, state IDLE.
  - If req[owner]=0 and spi_busy=1: gnt→0, strobes forced 0, state DRAIN.
- DRAIN:
  - Strobes masked; addr/data_in hold their last value.
  - When spi_busy=0, go to IDLE; the next grant comes the following cycle.
- Fairness: with all req held high and owners releasing after each transaction, grant order is 0,1,..,N_REQ-1,0.
- A requester that drops and immediately re-asserts req goes to the back of the rotation.
- Requesters must not strobe before seeing gnt. Strobes without gnt are dropped, never queued.
- Multiple simultaneous strobes from the owner pass through unchanged; the arbiter does not check them.
- rst in any state: immediate return to reset values next edge; the host is reset via spi_rst.
- req_busy[i] = spi_busy when gnt[i]=1, else 1. This is combinational from the registered gnt.

Optional Feature:
Macro SDSPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter counts consecutive spi_busy=1 cycles while in OWN or DRAIN; it is cleared when spi_busy=0.
  - When it reaches TIMEOUT_CYCLES:
    - spi_rst pulses high for 2 cycles.
    - gnt→0 and the state goes to IDLE.
    - pointer=owner.
    - timeout is set sticky; it is cleared only by rst.
- Undefined: no counter; timeout tied 0; spi_rst = rst plus the 1-cycle post-reset pulse only.

Test Plan:
- Reset then req=2'b11 → gnt=2'b01 one cycle later, owner=0; req_busy[1]=1.
- Owner 0 holds req, drives r_block with addr 0x00000010; requester 1 drives w_byte → spi_r_block=1 and spi_block_addr=0x10 one cycle later; spi_w_byte stays 0.
- Owner 0 drops req while spi_busy=1 for 20 cycles → gnt=0 immediately (DRAIN); gnt=2'b10 exactly 2 cycles after spi_busy falls.
- N_REQ=4, all req high, each owner releases after 1 transaction → grant order 0,1,2,3,0.
- rst asserted in OWN mid-transfer → next cycle gnt=0 and strobes=0; spi_rst high through rst plus 1 cycle; first grant after reset goes to requester 0.
- With SDSPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, spi_busy stuck high → at busy cycle 64 spi_rst=1 for 2 cycles, gnt=0, timeout=1 and stays 1 until rst.
